// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the RV32IM ALU control decoder: ALUOp classes,
// ALUControl operation codes, RV32 opcodes and a small funct3 helper.
package alu_ctrl_pkg;

  // Instruction classes from the main control unit
  localparam logic [2:0] ALUOP_LSJ    = 3'b000;
  localparam logic [2:0] ALUOP_BRANCH = 3'b001;
  localparam logic [2:0] ALUOP_RTYPE  = 3'b010;
  localparam logic [2:0] ALUOP_ITYPE  = 3'b011;
  localparam logic [2:0] ALUOP_RMUL   = 3'b100;
  localparam logic [2:0] ALUOP_UTYPE  = 3'b101;
  localparam logic [2:0] ALUOP_JUMP   = 3'b110;
  localparam logic [2:0] ALUOP_RSVD   = 3'b111;

  // Integer ALU operations
  localparam logic [5:0] ALU_ADD    = 6'b000000;
  localparam logic [5:0] ALU_SUB    = 6'b000001;
  localparam logic [5:0] ALU_SLL    = 6'b000010;
  localparam logic [5:0] ALU_SLT    = 6'b000011;
  localparam logic [5:0] ALU_SLTU   = 6'b000100;
  localparam logic [5:0] ALU_XOR    = 6'b000101;
  localparam logic [5:0] ALU_SRL    = 6'b000110;
  localparam logic [5:0] ALU_SRA    = 6'b000111;
  localparam logic [5:0] ALU_OR     = 6'b001000;
  localparam logic [5:0] ALU_AND    = 6'b001001;

  // Branch compare operations
  localparam logic [5:0] ALU_BEQ    = 6'b010000;
  localparam logic [5:0] ALU_BNE    = 6'b010001;
  localparam logic [5:0] ALU_BLT    = 6'b010010;
  localparam logic [5:0] ALU_BGE    = 6'b010011;
  localparam logic [5:0] ALU_BLTU   = 6'b010100;
  localparam logic [5:0] ALU_BGEU   = 6'b010101;

  // M-extension operations; low three bits equal funct3
  localparam logic [5:0] ALU_MUL    = 6'b100000;
  localparam logic [5:0] ALU_MULH   = 6'b100001;
  localparam logic [5:0] ALU_MULHSU = 6'b100010;
  localparam logic [5:0] ALU_MULHU  = 6'b100011;
  localparam logic [5:0] ALU_DIV    = 6'b100100;
  localparam logic [5:0] ALU_DIVU   = 6'b100101;
  localparam logic [5:0] ALU_REM    = 6'b100110;
  localparam logic [5:0] ALU_REMU   = 6'b100111;

  // Upper-immediate and jump operations
  localparam logic [5:0] ALU_LUI    = 6'b110000;
  localparam logic [5:0] ALU_AUIPC  = 6'b110001;
  localparam logic [5:0] ALU_JAL    = 6'b110010;

  // RV32 major opcodes
  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_RTYPE   = 7'b0110011;
  localparam logic [6:0] OP_ITYPE   = 7'b0010011;
  localparam logic [6:0] OP_LUI     = 7'b0110111;
  localparam logic [6:0] OP_AUIPC   = 7'b0010111;
  localparam logic [6:0] OP_JAL     = 7'b1101111;

  // funct7 values the decoder distinguishes
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  // funct3 to integer op, shared by register and immediate forms
  function automatic logic [5:0] base_op(input logic [2:0] f3);
    logic [5:0] op;
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Pure combinational decode of {ALUOp, opcode, funct3, funct7} into the
// ALUControl code and a decode-error flag. Illegal cases yield ADD.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [2:0] alu_op,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [5:0] code,
  output logic       illegal
);

  always_comb begin
    code    = ALU_ADD;
    illegal = 1'b0;
    case (alu_op)
      ALUOP_LSJ: begin
        code = ALU_ADD;
      end

      ALUOP_BRANCH: begin
        case (funct3)
          3'b000:  code = ALU_BEQ;
          3'b001:  code = ALU_BNE;
          3'b100:  code = ALU_BLT;
          3'b101:  code = ALU_BGE;
          3'b110:  code = ALU_BLTU;
          3'b111:  code = ALU_BGEU;
          default: illegal = 1'b1;
        endcase
      end

      ALUOP_RTYPE: begin
        if (funct7 == F7_BASE) begin
          code = base_op(funct3);
        end else if (funct7 == F7_ALT) begin
          // Only add and srl have alternate (sub/sra) encodings
          case (funct3)
            3'b000:  code = ALU_SUB;
            3'b101:  code = ALU_SRA;
            default: illegal = 1'b1;
          endcase
        end else begin
          illegal = 1'b1;
        end
      end

      ALUOP_ITYPE: begin
        case (funct3)
          3'b001: begin
            if (funct7 == F7_BASE) code = ALU_SLL;
            else                   illegal = 1'b1;
          end
          3'b101: begin
            // Shift-immediate: upper imm bits carry the srl/sra selector
            if (funct7 == F7_BASE || funct7 == F7_ALT)
              code = funct7[5] ? ALU_SRA : ALU_SRL;
            else
              illegal = 1'b1;
          end
          default: code = base_op(funct3);
        endcase
      end

      ALUOP_RMUL: begin
        if (funct7 == F7_MULDIV) code = {3'b100, funct3};
        else                     illegal = 1'b1;
      end

      ALUOP_UTYPE: begin
        if (opcode == OP_LUI)        code = ALU_LUI;
        else if (opcode == OP_AUIPC) code = ALU_AUIPC;
        else                         illegal = 1'b1;
      end

      ALUOP_JUMP: begin
        code = ALU_JAL;
      end

      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_control_gen.sv
// Registered ALU control generator: decode plus one output register stage.
// Define ALUCTRL_ILLEGAL_EN to add the registered 'illegal' output.
module alu_control_gen
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [2:0]             ALUOp,
  input  logic [INSTR_WIDTH-1:0] Instr_RV32IM,
  output logic [5:0]             ALUControl
`ifdef ALUCTRL_ILLEGAL_EN
  ,
  output logic                   illegal
`endif
);

  if (INSTR_WIDTH < 32 || WIDTH < 1) begin : g_param_check
    $error("alu_control_gen: INSTR_WIDTH must be >= 32 and WIDTH >= 1");
  end

  logic [5:0] dec_code;
  logic       dec_illegal;

  alu_ctrl_decode u_decode (
    .alu_op  (ALUOp),
    .opcode  (Instr_RV32IM[6:0]),
    .funct3  (Instr_RV32IM[14:12]),
    .funct7  (Instr_RV32IM[31:25]),
    .code    (dec_code),
    .illegal (dec_illegal)
  );

  // Register fields and immediates never affect the control code
  logic unused_instr_bits;
  assign unused_instr_bits = ^{Instr_RV32IM[24:15], Instr_RV32IM[11:7]};

  if (INSTR_WIDTH > 32) begin : g_wide_instr
    logic unused_instr_hi;
    assign unused_instr_hi = ^Instr_RV32IM[INSTR_WIDTH-1:32];
  end

  // No handshake: the register reloads on every rising edge.
  always_ff @(posedge clk) begin
    if (!rst_n) ALUControl <= ALU_ADD;
    else        ALUControl <= dec_code;
  end

`ifdef ALUCTRL_ILLEGAL_EN
  always_ff @(posedge clk) begin
    if (!rst_n) illegal <= 1'b0;
    else        illegal <= dec_illegal;
  end
`else
  logic unused_illegal;
  assign unused_illegal = dec_illegal;
`endif

endmodule

// File: tb/tb_alu_control_gen.sv
// Directed bench for alu_control_gen; checks the illegal flag too when
// built with ALUCTRL_ILLEGAL_EN.
module tb_alu_control_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  ALUOp;
  logic [31:0] Instr_RV32IM;
  logic [5:0]  ALUControl;
`ifdef ALUCTRL_ILLEGAL_EN
  logic        illegal;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_control_gen #(.WIDTH(32), .INSTR_WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ALUOp        (ALUOp),
    .Instr_RV32IM (Instr_RV32IM),
    .ALUControl   (ALUControl)
`ifdef ALUCTRL_ILLEGAL_EN
    ,
    .illegal      (illegal)
`endif
  );

  function automatic logic [31:0] mk_r(input logic [6:0] f7, input logic [2:0] f3,
                                       input logic [6:0] op);
    return {f7, 5'd2, 5'd1, f3, 5'd3, op};
  endfunction

  function automatic logic [31:0] mk_i(input logic [11:0] imm, input logic [2:0] f3,
                                       input logic [6:0] op);
    return {imm, 5'd1, f3, 5'd3, op};
  endfunction

  // Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge
  task automatic apply(input logic [2:0] op, input logic [31:0] instr);
    @(negedge clk);
    ALUOp        = op;
    Instr_RV32IM = instr;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [5:0] exp_code, input logic exp_ill);
    n_assert++;
    assert (ALUControl === exp_code)
    else begin
      n_fail++;
      $error("FAIL %s: ALUControl=%b expected %b", tag, ALUControl, exp_code);
    end
`ifdef ALUCTRL_ILLEGAL_EN
    n_assert++;
    assert (illegal === exp_ill)
    else begin
      n_fail++;
      $error("FAIL %s_illegal: illegal=%b expected %b", tag, illegal, exp_ill);
    end
`else
    if (exp_ill === 1'bx) $display("note: %s has unknown expected flag", tag);
`endif
  endtask

  task automatic step(input string tag, input logic [2:0] op, input logic [31:0] instr,
                      input logic [5:0] exp_code, input logic exp_ill);
    apply(op, instr);
    check(tag, exp_code, exp_ill);
  endtask

  logic [2:0] br_f3 [6];
  logic [5:0] br_exp[6];

  initial begin
    br_f3  = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
    br_exp = '{6'b010000, 6'b010001, 6'b010010, 6'b010011, 6'b010100, 6'b010101};

    // Reset held two cycles with an RMUL instruction on the inputs
    rst_n        = 1'b0;
    ALUOp        = 3'b100;
    Instr_RV32IM = mk_r(7'b0000001, 3'b000, 7'b0110011);
    @(posedge clk); #1;
    check("reset_c1", 6'b000000, 1'b0);
    @(posedge clk); #1;
    check("reset_c2", 6'b000000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("first_after_reset_mul", 6'b100000, 1'b0);

    // LSJ: lw, sw, jalr
    step("lsj_lw",   3'b000, mk_i(12'h004, 3'b000, 7'b0000011), 6'b000000, 1'b0);
    step("lsj_sw",   3'b000, mk_r(7'b1111111, 3'b000, 7'b0100011), 6'b000000, 1'b0);
    step("lsj_jalr", 3'b000, mk_i(12'hFFF, 3'b000, 7'b1100111), 6'b000000, 1'b0);

    // Branches
    for (int i = 0; i < 6; i++)
      step($sformatf("branch_f3_%0d", br_f3[i]), 3'b001,
           mk_r(7'b0000000, br_f3[i], 7'b1100011), br_exp[i], 1'b0);
    step("branch_f3_010_illegal", 3'b001, mk_r(7'b0000000, 3'b010, 7'b1100011), 6'b000000, 1'b1);
    step("branch_f3_011_illegal", 3'b001, mk_r(7'b0000000, 3'b011, 7'b1100011), 6'b000000, 1'b1);

    // R-type
    step("r_add",  3'b010, mk_r(7'b0000000, 3'b000, 7'b0110011), 6'b000000, 1'b0);
    step("r_sub",  3'b010, mk_r(7'b0100000, 3'b000, 7'b0110011), 6'b000001, 1'b0);
    step("r_sra",  3'b010, mk_r(7'b0100000, 3'b101, 7'b0110011), 6'b000111, 1'b0);
    step("r_srl",  3'b010, mk_r(7'b0000000, 3'b101, 7'b0110011), 6'b000110, 1'b0);
    step("r_and",  3'b010, mk_r(7'b0000000, 3'b111, 7'b0110011), 6'b001001, 1'b0);
    step("r_alt_sll_illegal", 3'b010, mk_r(7'b0100000, 3'b001, 7'b0110011), 6'b000000, 1'b1);
    step("r_f7_bad_illegal",  3'b010, mk_r(7'b0010000, 3'b100, 7'b0110011), 6'b000000, 1'b1);

    // I-type
    step("i_addi_abc",  3'b011, mk_i(12'hABC, 3'b000, 7'b0010011), 6'b000000, 1'b0);
    step("i_addi_b30",  3'b011, mk_i(12'h400, 3'b000, 7'b0010011), 6'b000000, 1'b0);
    step("i_srai",      3'b011, mk_i({7'b0100000, 5'd3}, 3'b101, 7'b0010011), 6'b000111, 1'b0);
    step("i_srli",      3'b011, mk_i({7'b0000000, 5'd3}, 3'b101, 7'b0010011), 6'b000110, 1'b0);
    step("i_slli",      3'b011, mk_i({7'b0000000, 5'd3}, 3'b001, 7'b0010011), 6'b000010, 1'b0);
    step("i_sltiu_eee", 3'b011, mk_i(12'hEEE, 3'b011, 7'b0010011), 6'b000100, 1'b0);
    step("i_ori",       3'b011, mk_i(12'hFFF, 3'b110, 7'b0010011), 6'b001000, 1'b0);
    step("i_slli_alt_illegal", 3'b011, mk_i({7'b0100000, 5'd3}, 3'b001, 7'b0010011), 6'b000000, 1'b1);
    step("i_srxi_bad_illegal", 3'b011, mk_i({7'b1100000, 5'd3}, 3'b101, 7'b0010011), 6'b000000, 1'b1);

    // M-extension
    for (int f = 0; f < 8; f++)
      step($sformatf("rmul_f3_%0d", f), 3'b100, mk_r(7'b0000001, f[2:0], 7'b0110011),
           {3'b100, f[2:0]}, 1'b0);
    step("rmul_f7_0_illegal", 3'b100, mk_r(7'b0000000, 3'b000, 7'b0110011), 6'b000000, 1'b1);

    // U-type, jump, reserved
    step("u_lui",   3'b101, {20'hABCDE, 5'd1, 7'b0110111}, 6'b110000, 1'b0);
    step("u_auipc", 3'b101, {20'h12345, 5'd1, 7'b0010111}, 6'b110001, 1'b0);
    step("u_badop_illegal", 3'b101, {20'h12345, 5'd1, 7'b0110011}, 6'b000000, 1'b1);
    step("jump_jal", 3'b110, {20'h0F00F, 5'd1, 7'b1101111}, 6'b110010, 1'b0);
    step("rsvd_illegal", 3'b111, mk_r(7'b0000001, 3'b111, 7'b0110011), 6'b000000, 1'b1);

    // Reset mid-stream has priority over a live input
    @(negedge clk);
    rst_n = 1'b0;
    ALUOp = 3'b110;
    Instr_RV32IM = {20'h0, 5'd1, 7'b1101111};
    @(posedge clk); #1;
    check("reset_priority", 6'b000000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("after_reset_jal", 6'b110010, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
